reg_bank_rd: RTL and testbench

REG_BANK_RD -- requirements
Module: reg_bank_rd

---
 rtl/reg_bank_rd.sv | 72 +++++++
 tb/tb_reg_bank_rd.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_rd.sv
// rtl/reg_bank_rd.sv - flop register bank with a 2-entry return FIFO on the read path
module reg_bank_rd #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] fifo [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_word;

  assign rd_gnt   = (count != 2'd2);
  assign rd_valid = (count != 2'd0);
  assign rd_data  = fifo[head];

  assign push = rd_req && rd_gnt;
  assign pop  = rd_valid && rd_ready;

  // Write-first: a same-cycle write to the requested register is what gets returned.
  assign push_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : regs[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        fifo[tail] <= push_word;
        tail       <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_rd.sv
// tb/tb_reg_bank_rd.sv - self-checking bench for reg_bank_rd: vector table, corner sequences, random vs model
module tb_reg_bank_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready;

  int total = 0;
  int bad = 0;

  reg_bank_rd #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_ready;
    logic        exp_gnt;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                              input logic rq, input logic [2:0] ra, input logic rr,
                              input logic eg, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_req = rq; v.rd_addr = ra; v.rd_ready = rr;
    v.exp_gnt = eg; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [31:0] mregs [8];
  logic [31:0] q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    // writes and requests during reset must be ignored
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h5A5A5A5A; rd_req = 1'b1; rd_addr = 3'd5;
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_gnt", rd_gnt, 1);
    check("rst_data", rd_data, 0);
    tick(); tick();
    check("rst_hold_valid", rd_valid, 0);
    idle();
    rst = 1'b0;

    rd_req = 1'b1; rd_addr = 3'd5;
    tick();
    rd_req = 1'b0;
    check("rst_rd5_valid", rd_valid, 1);
    check("rst_rd5_data", rd_data, 32'h0);
    tick();

    // mid-operation asynchronous reset
    write_reg(3'd5, 32'hCAFEF00D);
    rd_req = 1'b1; rd_addr = 3'd5; rd_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    check("mid_pre_valid", rd_valid, 1);
    check("mid_pre_data", rd_data, 32'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_gnt", rd_gnt, 1);
    check("mid_rst_data", rd_data, 0);
    tick();
    idle();
    rst = 1'b0;
    rd_req = 1'b1; rd_addr = 3'd5;
    tick();
    rd_req = 1'b0;
    check("mid_after_data", rd_data, 32'h0);
    check("mid_after_valid", rd_valid, 1);
    tick();
    check("mid_after_empty", rd_valid, 0);

    // vector table: write/read, bypass, full-FIFO gating, push+pop at count 1
    vecs[0]  = mk(1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 1, 1, 0, 32'h0);
    vecs[1]  = mk(1, 3'd6, 32'hAAAA5555, 1, 3'd3, 1, 1, 0, 32'h0);
    vecs[2]  = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 1, 1, 32'hDEADBEEF);
    vecs[3]  = mk(1, 3'd6, 32'h12345678, 1, 3'd6, 1, 1, 0, 32'h0);
    vecs[4]  = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 1, 1, 32'h12345678);
    vecs[5]  = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 1, 0, 32'h0);
    vecs[6]  = mk(0, 3'd0, 32'h0,        1, 3'd6, 1, 1, 0, 32'h0);
    vecs[7]  = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 1, 1, 32'h12345678);
    vecs[8]  = mk(0, 3'd0, 32'h0,        1, 3'd3, 0, 1, 0, 32'h0);
    vecs[9]  = mk(0, 3'd0, 32'h0,        1, 3'd6, 0, 1, 1, 32'hDEADBEEF);
    vecs[10] = mk(0, 3'd0, 32'h0,        1, 3'd0, 0, 0, 1, 32'hDEADBEEF);
    vecs[11] = mk(0, 3'd0, 32'h0,        1, 3'd0, 1, 0, 1, 32'hDEADBEEF);
    vecs[12] = mk(0, 3'd0, 32'h0,        1, 3'd0, 1, 1, 1, 32'h12345678);
    vecs[13] = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 1, 1, 32'h0);
    vecs[14] = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rd_req = vecs[i].rd_req; rd_addr = vecs[i].rd_addr; rd_ready = vecs[i].rd_ready;
      #1;
      check($sformatf("vec%0d_gnt", i), rd_gnt, vecs[i].exp_gnt);
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
      tick();
    end
    idle();

    // backpressure: regs 1,2,4 requested while consumer stalls
    write_reg(3'd1, 32'h0101AAAA);
    write_reg(3'd2, 32'h0202BBBB);
    write_reg(3'd4, 32'h0404CCCC);
    rd_ready = 1'b0;
    rd_req = 1'b1; rd_addr = 3'd1;
    check("bp_gnt_a", rd_gnt, 1);
    tick();
    rd_addr = 3'd2;
    check("bp_gnt_b", rd_gnt, 1);
    check("bp_data_b", rd_data, 32'h0101AAAA);
    tick();
    rd_addr = 3'd4;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_stall%0d_gnt", k), rd_gnt, 0);
      check($sformatf("bp_stall%0d_valid", k), rd_valid, 1);
      check($sformatf("bp_stall%0d_data", k), rd_data, 32'h0101AAAA);
      tick();
    end
    rd_ready = 1'b1;
    check("bp_pulse_gnt", rd_gnt, 0);
    tick();
    rd_ready = 1'b0;
    check("bp_reopen_gnt", rd_gnt, 1);
    check("bp_second_data", rd_data, 32'h0202BBBB);
    tick();
    rd_req = 1'b0;
    check("bp_full_gnt", rd_gnt, 0);
    check("bp_still_second", rd_data, 32'h0202BBBB);
    rd_ready = 1'b1;
    tick();
    check("bp_third_valid", rd_valid, 1);
    check("bp_third_data", rd_data, 32'h0404CCCC);
    tick();
    check("bp_drained", rd_valid, 0);

    // snapshot: queued word unaffected by a later write
    write_reg(3'd2, 32'h11111111);
    rd_ready = 1'b0;
    rd_req = 1'b1; rd_addr = 3'd2;
    tick();
    rd_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h22222222;
    tick();
    wr_en = 1'b0;
    check("snap_old", rd_data, 32'h11111111);
    rd_ready = 1'b1;
    tick();
    rd_req = 1'b1; rd_addr = 3'd2;
    tick();
    rd_req = 1'b0;
    check("snap_new_valid", rd_valid, 1);
    check("snap_new", rd_data, 32'h22222222);
    tick();

    // streaming: 16 back-to-back reads with the consumer always ready
    for (int i = 0; i < 8; i++) write_reg(i[2:0], i * 32'h01010101);
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rd_req = 1'b1; rd_addr = k[2:0];
      check($sformatf("st%0d_gnt", k), rd_gnt, 1);
      if (k > 0) begin
        check($sformatf("st%0d_valid", k), rd_valid, 1);
        check($sformatf("st%0d_data", k), rd_data, ((k - 1) % 8) * 32'h01010101);
      end
      tick();
    end
    rd_req = 1'b0;
    check("st_last_valid", rd_valid, 1);
    check("st_last_data", rd_data, 7 * 32'h01010101);
    tick();
    check("st_empty", rd_valid, 0);

    // random traffic against a queue-based reference
    for (int i = 0; i < 8; i++) begin
      mregs[i] = $urandom;
      write_reg(i[2:0], mregs[i]);
    end
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic do_push;
      logic do_pop;
      wr_en = ($urandom_range(1, 0) == 1);
      wr_addr = 3'($urandom_range(7, 0));
      wr_data = $urandom;
      rd_req = ($urandom_range(9, 0) < 7);
      rd_addr = 3'($urandom_range(7, 0));
      rd_ready = ($urandom_range(9, 0) < 6);
      #1;
      check("rnd_gnt", rd_gnt, (q.size() < 2) ? 1 : 0);
      check("rnd_valid", rd_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) check("rnd_data", rd_data, q[0]);
      do_pop = (q.size() > 0) && rd_ready;
      do_push = rd_req && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back((wr_en && wr_addr == rd_addr) ? wr_data : mregs[rd_addr]);
      if (wr_en) mregs[wr_addr] = wr_data;
      tick();
    end
    idle();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
